// File: rtl/adder_sequencer.sv
// 16-bit adder that time-shares one 4-bit ripple-carry adder over four nibbles.
// Optional macro SUB_MODE_EN adds a 'sub' input that selects a - b.

module full_adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       carry
);
    logic c_w;

    always_comb begin
        c_w = c_in;
        sum = 4'h0;
        for (int i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ c_w;
            c_w    = (a[i] & b[i]) | (c_w & (a[i] ^ b[i]));
        end
        carry = c_w;
    end
endmodule

module adder_sequencer (
    input  logic        clk,
    input  logic        rst,
`ifdef SUB_MODE_EN
    input  logic        sub,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] sum,
    output logic        c_out,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] sum_q;
    logic        carry_q;
    logic        c_out_q;
    logic [1:0]  idx_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        busy_q;

    logic [15:0] b_d;
    logic        carry_d;
    logic [3:0]  fa_a;
    logic [3:0]  fa_b;
    logic [3:0]  fa_sum;
    logic        fa_carry;

    // Subtraction is a + ~b + 1; c_in is ignored in that mode.
    always_comb begin
        b_d     = b;
        carry_d = c_in;
`ifdef SUB_MODE_EN
        if (sub) begin
            b_d     = ~b;
            carry_d = 1'b1;
        end
`endif
    end

    assign fa_a = a_q[{idx_q, 2'b00} +: 4];
    assign fa_b = b_q[{idx_q, 2'b00} +: 4];

    full_adder4 u_fa (
        .a     (fa_a),
        .b     (fa_b),
        .c_in  (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sum_q       <= 16'h0000;
            c_out_q     <= 1'b0;
            idx_q       <= 2'd0;
            carry_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b_d;
                        carry_q    <= carry_d;
                        idx_q      <= 2'd0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q[{idx_q, 2'b00} +: 4] <= fa_sum;
                    carry_q <= fa_carry;
                    idx_q   <= idx_q + 2'd1;
                    // Final nibble: its carry-out is the 16-bit carry-out.
                    if (idx_q == 2'd3) begin
                        c_out_q     <= fa_carry;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
endmodule

// File: tb/tb_adder_sequencer.sv
// Self-checking bench for adder_sequencer: vector table plus scoreboard queue.
// Subtraction vectors are exercised when SUB_MODE_EN is defined.

module tb_adder_sequencer;
    logic        clk = 1'b0;
    logic        rst;
`ifdef SUB_MODE_EN
    logic        sub;
`endif
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        c_out;
    logic        busy;

    always #5 clk = ~clk;

    adder_sequencer dut (
        .clk       (clk),
        .rst       (rst),
`ifdef SUB_MODE_EN
        .sub       (sub),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
    } vec_t;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                          input logic [15:0] es, input logic ec, input bit push);
        int n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("in_ready_timeout", 32'(in_ready), 32'd1);
        a        = av;
        b        = bv;
        c_in     = cv;
        in_valid = 1'b1;
        if (push) begin
            e.sum  = es;
            e.cout = ec;
            sb_q.push_back(e);
        end
        tick();
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        c_in     = 1'($urandom);
    endtask

    task automatic collect(input string name);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        check({name, "_latency"}, 32'(cyc), 32'd4);
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({name, "_sum"}, 32'(sum), 32'(e.sum));
            check({name, "_cout"}, 32'(c_out), 32'(e.cout));
        end
        check({name, "_in_ready_done"}, 32'(in_ready), 32'd0);
        check({name, "_busy_done"}, 32'(busy), 32'd1);
    endtask

    task automatic release_result(input string name);
        logic [15:0] held;
        held      = sum;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_out_valid_drop"}, 32'(out_valid), 32'd0);
        check({name, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        check({name, "_sum_retained"}, 32'(sum), 32'(held));
    endtask

    initial begin
        bit seen;
        vecs[0] = '{16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'h0008, 16'h0007, 1'b1, 16'h0010, 1'b0};
        vecs[3] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0;
        b         = 16'h0;
        c_in      = 1'b0;
`ifdef SUB_MODE_EN
        sub       = 1'b0;
`endif
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'h0);
        check("rst_cout", 32'(c_out), 32'd0);

        // Reset wins over a simultaneous request.
        in_valid = 1'b1;
        a        = 16'h1111;
        tick();
        check("rst_prio_busy", 32'(busy), 32'd0);
        check("rst_prio_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            accept(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, 1'b1);
            collect($sformatf("vec%0d", i));
            release_result($sformatf("vec%0d", i));
        end

        // Consumer stalls in DONE while a new request is offered.
        accept(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b1);
        collect("stall");
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            a        = 16'h0F00 + 16'(k);
            b        = 16'h00F0;
            out_ready = 1'b0;
            tick();
            check($sformatf("stall%0d_sum", k), 32'(sum), 32'h3333);
            check($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
            check($sformatf("stall%0d_out_valid", k), 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stall_idle_in_ready", 32'(in_ready), 32'd1);
        check("stall_idle_out_valid", 32'(out_valid), 32'd0);
        check("stall_idle_busy", 32'(busy), 32'd0);
        accept(16'h0100, 16'h0200, 1'b1, 16'h0301, 1'b0, 1'b1);
        collect("after_stall");
        release_result("after_stall");

        // Reset with idx=2 in RUN discards the operation.
        accept(16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_sum", 32'(sum), 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_result", 32'(seen), 32'd0);

`ifdef SUB_MODE_EN
        sub = 1'b1;
        accept(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b1, 1'b1);
        sub = 1'b0;
        collect("sub0");
        release_result("sub0");
        sub = 1'b1;
        accept(16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0, 1'b1);
        sub = 1'b0;
        collect("sub1");
        release_result("sub1");
`endif

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/adder_sequencer.md
ADDER_SEQUENCER -- requirements
Module: adder_sequencer

Interface
- REQ-001: The block SHALL have one clock and a synchronous, active-high reset.
- REQ-002: clk  input  1  rising-edge clock for all state.
- REQ-003: rst  input  1  synchronous, active-high reset.
- REQ-004: in_valid  input  1  operand request.
- REQ-005: in_ready  output  1  block idle, able to accept operands.
- REQ-006: a  input  16  operand A.
- REQ-007: b  input  16  operand B.
- REQ-008: c_in  input  1  carry-in for bit 0.
- REQ-009: out_valid  output  1  result available.
- REQ-010: out_ready  input  1  consumer accepts result.
- REQ-011: sum  output  16  registered result.
- REQ-012: c_out  output  1  registered carry out of bit 15.
- REQ-013: busy  output  1  high in RUN or DONE.

Function
- REQ-014: The block SHALL compute the 16-bit sum {c_out,sum} = a + b + c_in, using one instance of the existing 4-bit ripple-carry adder full_adder4 (ports a, b, c_in, sum, carry), time-shared across four nibbles.
- REQ-015: The FSM SHALL have three states: IDLE, RUN and DONE.
- REQ-016: IDLE SHALL drive in_ready=1; RUN and DONE SHALL drive in_ready=0.
- REQ-017: In IDLE, on an edge with in_valid=1, the block SHALL:
  - latch a and b into internal registers;
  - load carry_r with c_in;
  - set the nibble index idx to 0;
  - go to RUN.
- REQ-018: Each RUN cycle SHALL apply a_r[4*idx+3:4*idx], b_r[4*idx+3:4*idx] and carry_r to the adder.
- REQ-019: At the end of each RUN cycle, sum_r nibble idx SHALL take the adder sum, carry_r SHALL take the adder carry, and idx SHALL increment.
- REQ-020: RUN SHALL last exactly 4 cycles, processing nibble 0 first; after idx=3 the FSM SHALL go to DONE.
- REQ-021: Latency: out_valid SHALL rise exactly 4 clocks after the accepting edge.
- REQ-022: In DONE, out_valid SHALL be 1, and sum and c_out SHALL be held stable until an edge with out_ready=1.
- REQ-023: On an edge in DONE with out_ready=1, the FSM SHALL go to IDLE; sum and c_out SHALL retain their values, and out_valid SHALL drop.
- REQ-024: Minimum spacing between accepted requests SHALL be 6 cycles: 1 accept, 4 RUN, 1 DONE.
- REQ-025: Changes on a, b or c_in after acceptance SHALL NOT affect the result in flight.
- REQ-026: in_valid in RUN or DONE SHALL be ignored; there is no queuing.
- REQ-027: out_ready outside DONE SHALL be ignored.
- REQ-028: Carry SHALL propagate across nibble boundaries through carry_r only; 16-bit wrap-around SHALL be reported solely through c_out.

Reset
- REQ-029: When rst=1 at an edge, the block SHALL go to IDLE and apply the reset values in REQ-030, regardless of state.
- REQ-030: Reset values:
  - in_ready=1, out_valid=0, busy=0;
  - sum=0x0000, c_out=0;
  - idx=0, carry_r=0.
- REQ-031: Reset during RUN or DONE SHALL discard the operation in flight; no out_valid pulse SHALL follow.
- REQ-032: rst SHALL take priority over in_valid and out_ready on the same edge.

Configuration
- REQ-033: Macro SUB_MODE_EN: when defined, the block SHALL add an input port sub (1 bit).
- REQ-034: With SUB_MODE_EN defined and sub=1 at acceptance, the block SHALL latch ~b, load carry_r=1 and ignore c_in, giving sum=a-b and c_out=1 meaning no borrow.
- REQ-035: With SUB_MODE_EN defined and sub=0 at acceptance, the block SHALL behave as without the macro.
- REQ-036: Without SUB_MODE_EN, the sub port SHALL NOT exist, and the block SHALL perform addition only.

Verification
- REQ-037: a=0x0002, b=0x0003, c_in=0 accepted -> out_valid high 4 clocks later; sum=0x0005, c_out=0.
- REQ-038: a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1; carry propagated through all four nibbles.
- REQ-039: a=0x0008, b=0x0007, c_in=1 -> sum=0x0010, c_out=0; nibble-0 carry reaches nibble 1.
- REQ-040: out_ready held 0 for 3 cycles in DONE, and in_valid=1 with new operands during that time -> sum stable, in_ready=0, new operands not accepted; out_ready=1 -> IDLE next cycle, then new operands accepted.
- REQ-041: rst=1 while idx=2 in RUN -> next cycle IDLE, in_ready=1, out_valid=0, sum=0x0000; no result produced.
- REQ-042: With SUB_MODE_EN: a=0x0005, b=0x0003, sub=1 -> sum=0x0002, c_out=1. a=0x0003, b=0x0005, sub=1 -> sum=0xFFFE, c_out=0.
